attn_matmul_scheduler: RTL and testbench
========================================

Name: attn_matmul_scheduler

Overview:
Sequences one shared matrix-multiply datapath through the attention operation list. The default list is Q=XWq, K=XWk, V=XWv, S=QK^T and O=PV, giving op indices 0..4.
- Per op: drives the operand-mux select, pulses the multiplier START, waits for its DONE, then issues a one-cycle result write strobe.
- Sits between the attention top-level control and the matmul unit plus its operand/result muxing.
- Supports per-run op masking, a done-timeout watchdog and abort.

Parameters:
NUM_OPS, 5, number of schedulable matmul operations (op indices 0..NUM_OPS-1)
OP_W, 3, width of the op index; must satisfy 2**OP_W >= NUM_OPS
TIMEOUT, 15, maximum cycles spent in WAIT before error (>=1)
TMO_W, 4, watchdog counter width; must satisfy 2**TMO_W > TIMEOUT

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  run request; sampled only when busy=0
op_mask  in  NUM_OPS  bit i=1 means op i is executed this run; sampled with start
abort  in  1  terminates a run in progress
mm_start  out  1  one-cycle START pulse to the matmul unit
mm_op_sel  out  OP_W  operand/result mux select = current op index
mm_done  in  1  DONE from the matmul unit
wr_en  out  1  one-cycle strobe: latch matmul result for op wr_op
wr_op  out  OP_W  op index qualifying wr_en
busy  out  1  high in every state except IDLE
done  out  1  one-cycle end-of-run pulse
error  out  1  sticky watchdog flag; cleared on the next accepted start
ops_done  out  OP_W+1  ops completed in the current or most recent run

Behaviour:
- Reset (reset_n=0, asynchronous): all outputs 0, state IDLE, mask/idx/timer 0. Reset mid-run aborts immediately. No wr_en or done is issued.
- States: IDLE, ISSUE, WAIT, WRITE, FINISH, ERROR. All outputs are registered or decoded from registered state only; no combinational in-to-out path.
- IDLE, on start=1:
  - Latch op_mask; clear ops_done and error.
  - If mask==0, go to FINISH.
  - Otherwise idx = lowest set bit and go to ISSUE.
- ISSUE:
  - mm_start=1 for exactly this cycle.
  - mm_op_sel=idx; it holds stable from ISSUE through WRITE.
  - Clear the timer, then go to WAIT.
- WAIT:
  - mm_start=0.
  - If mm_done=1, go to WRITE.
  - Else, if timer==TIMEOUT-1, go to ERROR.
  - Else increment timer.
- WRITE:
  - wr_en=1 and wr_op=idx for this one cycle; ops_done increments.
  - If a set mask bit exists above idx, set idx to the next such bit and go to ISSUE; otherwise go to FINISH.
- FINISH: done=1 for one cycle, then go to IDLE.
- ERROR: error=1, sticky; done=1 for one cycle; go to IDLE. ops_done holds the count of completed ops.
- Timing: a matmul that asserts DONE one cycle after START costs 3 cycles per op.
  - Start accepted at edge 0: op k ISSUE at cycle 1+3k; done high at cycle 1+3n for n enabled ops.
  - For the full default mask (n=5), done is high at cycle 16.
- abort=1 in any non-IDLE state: next state is IDLE; mm_start, wr_en and done stay 0; ops_done and error hold.
  - abort with mm_done in the same WAIT cycle: abort wins, no wr_en.
  - abort in IDLE: ignored.
- start while busy=1: ignored, and op_mask is not resampled. start and abort together in IDLE: start is accepted.
- mm_done in any state other than WAIT: ignored (stale or level DONE). It must not cause a double write.
- mm_done held high: each op still advances only through ISSUE→WAIT→WRITE, exactly one wr_en per op.
- ops_done never wraps: the maximum is NUM_OPS, which is less than 2**(OP_W+1).

Test Plan:
- Model matmul with DONE = registered START. Reset, start, op_mask=5'b11111 → mm_start at cycles 1,4,7,10,13 with mm_op_sel 0..4; wr_en at 3,6,9,12,15 with wr_op 0..4; done at 16; ops_done=5; error=0.
- op_mask=5'b10010 → exactly two ops (idx 1 then 4); wr_op sequence 1,4; done at cycle 7; ops_done=2. op_mask=0 → done at cycle 1, no mm_start.
- Matmul never asserts DONE, TIMEOUT=15 → ERROR after 15 WAIT cycles; error=1 and done pulse; no wr_en; ops_done=0. Next start clears error.
- abort asserted together with mm_done during op 2's WAIT → IDLE next cycle; no wr_en for op 2; no done; ops_done=2. Re-start runs normally.
- Second start pulse during busy, plus an mm_done glitch while in WRITE → no restart; no extra wr_en; run completes with the original mask.
- reset_n pulled low during WAIT of op 3 → all outputs 0 asynchronously; after release, idle with busy=0 until the next start.

Source files
------------

// File: rtl/attn_matmul_scheduler.sv
// Steps one shared matmul datapath through the enabled attention ops, one op at a time.
// Latency: start -> first mm_start 1 cycle; 3 cycles per op when DONE follows START by one cycle.
// Backpressure: waits on mm_done per op (watchdog-bounded); start is ignored while busy.
module attn_matmul_scheduler #(
    parameter int NUM_OPS = 5,
    parameter int OP_W    = 3,
    parameter int TIMEOUT = 15,
    parameter int TMO_W   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [NUM_OPS-1:0] op_mask,
    input  logic               abort,
    output logic               mm_start,
    output logic [OP_W-1:0]    mm_op_sel,
    input  logic               mm_done,
    output logic               wr_en,
    output logic [OP_W-1:0]    wr_op,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [OP_W:0]      ops_done
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ISSUE, ST_WAIT, ST_WRITE, ST_FINISH, ST_ERROR
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t             state;
    logic [NUM_OPS-1:0] mask;
    logic [OP_W-1:0]    idx;
    logic [TMO_W-1:0]   timer;
    logic [OP_W-1:0]    first_idx;
    logic [OP_W-1:0]    next_idx;
    logic               has_next;

    // Descending scans leave the lowest qualifying bit as the final assignment.
    always_comb begin
        first_idx = '0;
        for (int i = NUM_OPS - 1; i >= 0; i--) begin
            if (op_mask[i]) first_idx = OP_W'(i);
        end
    end

    always_comb begin
        next_idx = '0;
        has_next = 1'b0;
        for (int i = NUM_OPS - 1; i >= 0; i--) begin
            if (mask[i] && (OP_W'(i) > idx)) begin
                next_idx = OP_W'(i);
                has_next = 1'b1;
            end
        end
    end

    assign mm_op_sel = idx;
    assign wr_op     = idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            mask     <= '0;
            idx      <= '0;
            timer    <= '0;
            mm_start <= 1'b0;
            wr_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            ops_done <= '0;
        end else begin
            mm_start <= 1'b0;
            wr_en    <= 1'b0;
            done     <= 1'b0;
            if (abort && state != ST_IDLE) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            mask     <= op_mask;
                            ops_done <= '0;
                            error    <= 1'b0;
                            busy     <= 1'b1;
                            if (op_mask == '0) begin
                                state <= ST_FINISH;
                                done  <= 1'b1;
                            end else begin
                                state    <= ST_ISSUE;
                                idx      <= first_idx;
                                mm_start <= 1'b1;
                            end
                        end
                    end
                    ST_ISSUE: begin
                        timer <= '0;
                        state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (mm_done) begin
                            state    <= ST_WRITE;
                            wr_en    <= 1'b1;
                            ops_done <= ops_done + 1'b1;
                        end else if (timer == TMO_LAST) begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                            done  <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    // mm_done is not looked at here, so a stale DONE cannot write twice.
                    ST_WRITE: begin
                        if (has_next) begin
                            state    <= ST_ISSUE;
                            idx      <= next_idx;
                            mm_start <= 1'b1;
                        end else begin
                            state <= ST_FINISH;
                            done  <= 1'b1;
                        end
                    end
                    ST_FINISH, ST_ERROR: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_attn_matmul_scheduler.sv
// Randomized bench for attn_matmul_scheduler against a cycle-schedule reference model.
module tb_attn_matmul_scheduler;

    localparam int NUM_OPS = 5;
    localparam int OP_W    = 3;
    localparam int TIMEOUT = 15;
    localparam int TMO_W   = 4;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    logic [NUM_OPS-1:0] op_mask = '0;
    logic               abort = 1'b0;
    logic               mm_start;
    logic [OP_W-1:0]    mm_op_sel;
    logic               mm_done;
    logic               wr_en;
    logic [OP_W-1:0]    wr_op;
    logic               busy;
    logic               done;
    logic               error;
    logic [OP_W:0]      ops_done;

    int n_checks = 0;
    int n_errors = 0;

    // matmul stand-in: 0 = DONE mm_lat cycles after START, 1 = never, 2 = held high,
    // 3 = like 0 but DONE lingers one extra cycle (into WRITE)
    int   mm_mode = 0;
    int   mm_lat  = 1;
    int   mm_cnt  = 0;
    logic mm_done_q;

    attn_matmul_scheduler #(
        .NUM_OPS(NUM_OPS), .OP_W(OP_W), .TIMEOUT(TIMEOUT), .TMO_W(TMO_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op_mask(op_mask), .abort(abort),
        .mm_start(mm_start), .mm_op_sel(mm_op_sel), .mm_done(mm_done),
        .wr_en(wr_en), .wr_op(wr_op), .busy(busy), .done(done), .error(error),
        .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mm_done   <= 1'b0;
            mm_done_q <= 1'b0;
            mm_cnt    <= 0;
        end else begin
            mm_done_q <= mm_done;
            if (mm_mode == 2) begin
                mm_done <= 1'b1;
            end else if (mm_mode == 1) begin
                mm_done <= 1'b0;
            end else if (mm_start) begin
                mm_cnt  <= mm_lat - 1;
                mm_done <= (mm_lat == 1);
            end else if (mm_cnt != 0) begin
                mm_cnt  <= mm_cnt - 1;
                mm_done <= (mm_cnt == 1);
            end else begin
                mm_done <= (mm_mode == 3) && mm_done && !mm_done_q;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One run: start at edge 0, then compare every cycle against the schedule computed
    // from the op list. abort_k >= 0 aborts in the WAIT of the abort_k-th enabled op.
    task automatic do_run(input logic [NUM_OPS-1:0] m, input int lat, input int mode,
                          input int abort_k, input bit poke);
        int ops[$];
        bit es[64], ew[64], ed[64];
        int esel[64], eop[64], eod[64];
        int n, step, issues, writes, last_c, ab_c, err_c;
        for (int i = 0; i < NUM_OPS; i++) if (m[i]) ops.push_back(i);
        n = ops.size();
        if (mode == 2) lat = 1;
        step  = lat + 2;
        ab_c  = (abort_k >= 0) ? 1 + step * abort_k + lat : -1;
        err_c = 1000;
        for (int c = 0; c < 64; c++) begin
            es[c] = 0; ew[c] = 0; ed[c] = 0; esel[c] = 0; eop[c] = 0;
        end
        issues = (mode == 1) ? ((n > 0) ? 1 : 0) : ((abort_k >= 0) ? abort_k + 1 : n);
        writes = (mode == 1) ? 0 : ((abort_k >= 0) ? abort_k : n);
        for (int k = 0; k < issues; k++) begin
            es[1 + step * k] = 1;
            esel[1 + step * k] = ops[k];
        end
        for (int k = 0; k < writes; k++) begin
            ew[2 + step * k + lat] = 1;
            eop[2 + step * k + lat] = ops[k];
        end
        if (abort_k >= 0) begin
            last_c = ab_c;
        end else if (mode == 1 && n > 0) begin
            last_c = 2 + TIMEOUT;
            err_c  = last_c;
            ed[last_c] = 1;
        end else begin
            last_c = 1 + step * n;
            ed[last_c] = 1;
        end
        for (int c = 0; c < 64; c++) begin
            eod[c] = 0;
            for (int k = 0; k < writes; k++) if (2 + step * k + lat <= c) eod[c]++;
        end

        mm_mode = mode;
        mm_lat  = lat;
        op_mask = m;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        op_mask = NUM_OPS'($urandom);
        for (int c = 1; c <= last_c + 2; c++) begin
            chk($sformatf("mm_start@%0d", c), mm_start, es[c]);
            chk($sformatf("wr_en@%0d", c), wr_en, ew[c]);
            chk($sformatf("done@%0d", c), done, ed[c]);
            chk($sformatf("busy@%0d", c), busy, c <= last_c);
            chk($sformatf("error@%0d", c), error, c >= err_c);
            chk($sformatf("ops_done@%0d", c), ops_done, eod[c]);
            if (es[c]) chk($sformatf("mm_op_sel@%0d", c), mm_op_sel, esel[c]);
            if (ew[c]) begin
                chk($sformatf("wr_op@%0d", c), wr_op, eop[c]);
                chk($sformatf("sel_hold@%0d", c), mm_op_sel, eop[c]);
            end
            abort = (c == ab_c);
            start = poke && (c == 2 || c == 3);
            if (poke) op_mask = NUM_OPS'($urandom);
            @(posedge clk);
            #1;
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        int m, lat, mode, ak;
        bit pk;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_mm_start", mm_start, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_ops_done", ops_done, 0);
        chk("rst_sel", mm_op_sel, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        do_run(5'b11111, 1, 0, -1, 0);
        do_run(5'b10010, 1, 0, -1, 0);
        do_run(5'b00000, 1, 0, -1, 0);
        do_run(5'b00001, 1, 1, -1, 0);   // watchdog
        do_run(5'b01100, 1, 0, -1, 0);   // error cleared by this start
        do_run(5'b11111, 1, 0, 2, 0);    // abort together with DONE in op 2's WAIT
        do_run(5'b11111, 1, 0, -1, 0);
        do_run(5'b10110, 1, 3, -1, 1);   // second start plus DONE lingering into WRITE
        do_run(5'b11011, 1, 2, -1, 0);   // DONE held high

        for (int r = 0; r < 16; r++) begin
            m    = $urandom_range(0, 31);
            lat  = $urandom_range(1, 4);
            mode = $urandom_range(0, 5);
            if (mode > 3) mode = 0;
            ak = -1;
            pk = 0;
            if (m != 0 && mode != 1) begin
                if ($urandom_range(0, 3) == 0) ak = $urandom_range(0, $countones(m[4:0]) - 1);
                else pk = $urandom_range(0, 1) == 1;
            end
            do_run(NUM_OPS'(m), lat, mode, ak, pk);
        end

        // asynchronous reset in the WAIT of op 3 (cycle 11 with one-cycle DONE)
        mm_mode = 0;
        mm_lat  = 1;
        op_mask = 5'b11111;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_ops_done", ops_done, 3);
        reset_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_ops_done", ops_done, 0);
        chk("arst_sel", mm_op_sel, 0);
        chk("arst_mm_start", mm_start, 0);
        #10;
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst_busy%0d", c), busy, 0);
            chk($sformatf("post_rst_wr%0d", c), wr_en + done + mm_start, 0);
        end
        do_run(5'b11111, 1, 0, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, %0d errors so far", n_errors);
        $fatal(1);
    end

endmodule
